// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding
// imem requests, arbitrates EX/ID redirects, and feeds the IF/ID slot.
//
// Ports:
//   cpu_clk, cpu_rst          clock, synchronous active-high reset
//   ex_redirect, ex_target    taken branch/jalr from EX (highest priority)
//   id_redirect, id_target    jal from ID (ignored while stalled)
//   stall                     hazard unit holds the IF/ID slot
//   imem_req/addr/gnt         request channel, addr stable until gnt
//   imem_rvalid/rdata         response channel, one outstanding max
//   if_valid/pc/pc4/inst      IF/ID slot; inst is NOP_INST when invalid
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] skid_q, skid_d;
  logic        kill_q, kill_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic        consumed;
  logic        slot_free;
  logic        redir;
  logic [31:0] redir_tgt;

  assign consumed  = if_valid_q & ~stall;
  assign slot_free = ~if_valid_q | consumed;

  // A jal in ID must not fire while its own slot is held.
  assign redir     = ex_redirect | (id_redirect & ~stall);
  assign redir_tgt = ex_redirect ? ex_target : id_target;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    skid_d     = skid_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;

    if (redir) begin
      pc_d       = redir_tgt & ~32'h3;
      if_valid_d = 1'b0;
      if_inst_d  = NOP_INST;
      skid_d     = NOP_INST;
      state_d    = REQ;
      unique case (state_q)
        // In-flight fetch belongs to the old path:
        // drop it now or mark it for dropping.
        WAIT: begin
          if (imem_rvalid) begin
            kill_d = 1'b0;
          end else begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end
        default: ;
      endcase
    end else begin
      if (consumed) begin
        if_valid_d = 1'b0;
        if_inst_d  = NOP_INST;
      end
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = REQ;
            end else if (slot_free) begin
              if_valid_d = 1'b1;
              if_inst_d  = imem_rdata;
              if_pc_d    = fetch_pc_q;
              state_d    = REQ;
            end else begin
              skid_d  = imem_rdata;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            if_valid_d = 1'b1;
            if_inst_d  = skid_q;
            if_pc_d    = fetch_pc_q;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      skid_q     <= NOP_INST;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_inst_q  <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      skid_q     <= skid_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc_q + 32'd4;
  assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: memory model with random gnt/latency,
// program-order scoreboard of delivered instructions, redirect and reset.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;

  fetch_ctrl dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .id_redirect (id_redirect),
    .id_target   (id_target),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .if_inst     (if_inst)
  );

  always #5 cpu_clk = ~cpu_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // reference model: program-order expectations
  logic [31:0] exp_pc    = RST_PC;
  int          live      = 0;
  bit          out_busy  = 0;
  bit          out_dead  = 0;
  logic [31:0] out_addr  = '0;
  int          out_dly   = 0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = '0;
  bit          chk_redir = 0;
  logic [31:0] redir_tgt = '0;
  int          rst_age   = 0;
  int          idle_run  = 0;
  int          consumed_n = 0;

  // stimulus knobs
  int p_gnt = 100, p_stall = 0, p_ex = 0, p_id = 0, dly_max = 1;
  bit force_ex = 0;
  logic [31:0] force_tgt = '0;

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(3) == 0) t = {28'hFFFF_FFF, t[3:0]};
    else t = t & 32'h0000_3FFF;
    return t;
  endfunction

  task automatic tick(input bit rst_now);
    bit stl, ex, id, gnt, rv, redir, cons;
    logic [31:0] ext, idt, tgt, rd;
    @(negedge cpu_clk);

    chk("pc4", if_pc4, if_pc + 32'd4);
    if (!if_valid) chk("nop_inst", if_inst, NOP);
    chk("valid", 32'(if_valid), 32'(live > 0));
    chk("live_max", 32'(live > 2), 32'd0);
    if (imem_req) begin
      chk("one_out", 32'(out_busy), 32'd0);
      chk("skid_empty", 32'(live > 1), 32'd0);
      chk("align", {30'd0, imem_addr[1:0]}, 32'd0);
    end
    if (prev_wait) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (chk_redir) begin
      chk("redir_clr", 32'(if_valid), 32'd0);
      if (!out_busy) begin
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, redir_tgt);
      end
    end
    if (rst_age == 1) begin
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_pc", if_pc, RST_PC);
      chk("rst_inst", if_inst, NOP);
      chk("rst_req", 32'(imem_req), 32'd0);
    end
    if (rst_age == 2) begin
      chk("rst2_valid", 32'(if_valid), 32'd0);
      chk("rst2_req", 32'(imem_req), 32'd1);
      chk("rst2_addr", imem_addr, RST_PC);
    end
    chk("progress", 32'(idle_run > 40), 32'd0);

    stl = ($urandom % 100) < p_stall;
    ex  = ($urandom % 100) < p_ex;
    id  = ($urandom % 100) < p_id;
    ext = rand_tgt();
    idt = rand_tgt();
    if (rst_age == 1) begin
      ex = 0;
      id = 0;
    end
    if (force_ex) begin
      ex = 1;
      ext = force_tgt;
      force_ex = 0;
    end
    rv  = out_busy && (out_dly == 1);
    gnt = imem_req && !rst_now && (($urandom % 100) < p_gnt);
    rd  = rv ? mem_word(out_addr) : $urandom;

    if (rv) out_busy = 0;
    else if (out_busy) out_dly--;

    redir = ex | (id & ~stl);
    tgt   = ex ? ext : idt;

    if (rst_now) begin
      exp_pc    = RST_PC;
      live      = 0;
      prev_wait = 0;
      chk_redir = 0;
      idle_run  = 0;
      rst_age   = 1;
      if (out_busy) begin
        out_dly  = 1;
        out_dead = 1;
      end
    end else begin
      rst_age = (rst_age == 0 || rst_age == 2) ? 0 : rst_age + 1;
      cons = if_valid & ~stl;
      if (cons) begin
        chk("slot_pc", if_pc, exp_pc);
        chk("slot_inst", if_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        live--;
        consumed_n++;
      end
      if (rv && !out_dead && !redir) live++;
      if (gnt) begin
        out_busy = 1;
        out_dead = 0;
        out_addr = imem_addr;
        out_dly  = 1 + ($urandom % dly_max);
      end
      if (redir && out_busy) out_dead = 1;
      if (redir) begin
        live      = 0;
        exp_pc    = tgt & ~32'h3;
        redir_tgt = tgt & ~32'h3;
      end
      chk_redir = redir;
      prev_wait = imem_req & ~gnt & ~redir;
      prev_addr = imem_addr;
      if (cons || redir) idle_run = 0;
      else if (!stl) idle_run++;
    end

    cpu_rst     = rst_now;
    stall       = stl;
    ex_redirect = ex;
    ex_target   = ext;
    id_redirect = id;
    id_target   = idt;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rd;
  endtask

  initial begin
    int c0;
    cpu_rst     = 1'b1;
    stall       = 1'b0;
    ex_redirect = 1'b0;
    ex_target   = '0;
    id_redirect = 1'b0;
    id_target   = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // zero-wait memory: one instruction every 2 cycles
    tick(1);
    repeat (6) tick(0);
    c0 = consumed_n;
    repeat (40) tick(0);
    chk("throughput", consumed_n - c0, 32'd20);

    // misaligned target, then sequential wrap at top of memory
    force_ex = 1;
    force_tgt = 32'h0000_0102;
    repeat (20) tick(0);
    force_ex = 1;
    force_tgt = 32'hFFFF_FFF4;
    repeat (20) tick(0);

    // randomized traffic with stalls, redirects and resets
    p_gnt = 60; p_stall = 30; p_ex = 4; p_id = 4; dly_max = 3;
    repeat (3000) tick(rst_age == 0 && ($urandom % 200) == 0);

    // heavy stall pressure to exercise the skid path
    p_stall = 70; p_gnt = 90; dly_max = 2; p_ex = 2; p_id = 2;
    repeat (1000) tick(0);

    chk("total_progress", 32'(consumed_n > 300), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
